local_buffer_dp: RTL and testbench



---
 rtl/local_buffer_dp.sv | 193 +++++++++++++++++++
 tb/tb_local_buffer_dp.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_buffer_dp.sv
// True-dual-port local buffer with lane write masks, cross-port forwarding and a clear sequencer.
// Defining LB_COLL_CNT_EN adds a saturating write-write collision counter (coll_cnt, coll_cnt_clr).
module local_buffer_dp #(
    parameter int DATA_W = 128,
    parameter int LANES  = 8,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CK,
    input  logic              rst,
    input  logic              a_oe,
    input  logic [LANES-1:0]  a_webn,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_di,
    output logic [DATA_W-1:0] a_do,
    input  logic              b_oe,
    input  logic [LANES-1:0]  b_webn,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_di,
    output logic [DATA_W-1:0] b_do,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              coll_ww
`ifdef LB_COLL_CNT_EN
    ,
    input  logic              coll_cnt_clr,
    output logic [15:0]       coll_cnt
`endif
);

    localparam int LANE_W = DATA_W / LANES;
    localparam logic [ADDR_W:0]   DEPTH_X  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } clr_state_e;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              clr_busy_q;
    logic              clr_done_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] a_do_q, a_do_d;
    logic [DATA_W-1:0] b_do_q, b_do_d;
    logic              coll_ww_q, coll_ww_d;

    logic              a_ok, b_ok, same, user_en;
    logic [DATA_W-1:0] a_bm, b_bm_raw, b_bm, ovl;
    logic [DATA_W-1:0] a_old, b_old;
    logic [DATA_W-1:0] a_wdata_d, b_wdata_d;
    logic              a_we_d, b_we_d;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] webn);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int i = 0; i < LANES; i++) begin
            m[i*LANE_W +: LANE_W] = {LANE_W{~webn[i]}};
        end
        return m;
    endfunction

    always_comb begin
        user_en  = (state_q != S_CLEAR);
        a_ok     = ({1'b0, a_addr} < DEPTH_X);
        b_ok     = ({1'b0, b_addr} < DEPTH_X);
        same     = a_ok && b_ok && (a_addr == b_addr);
        a_bm     = (user_en && a_ok) ? lane_mask(a_webn) : '0;
        b_bm_raw = (user_en && b_ok) ? lane_mask(b_webn) : '0;
        ovl      = same ? (a_bm & b_bm_raw) : '0;
        // Port A owns any lane both ports write at the same address.
        b_bm     = b_bm_raw & ~ovl;
        a_old    = a_ok ? mem_q[a_addr] : '0;
        b_old    = b_ok ? mem_q[b_addr] : '0;

        if (same) begin
            a_wdata_d = (a_old & ~(a_bm | b_bm)) | (a_di & a_bm) | (b_di & b_bm);
            a_we_d    = |(a_bm | b_bm);
            b_wdata_d = '0;
            b_we_d    = 1'b0;
        end else begin
            a_wdata_d = (a_old & ~a_bm) | (a_di & a_bm);
            a_we_d    = |a_bm;
            b_wdata_d = (b_old & ~b_bm) | (b_di & b_bm);
            b_we_d    = |b_bm;
        end

        // Reads see their own port's pre-write data but the other port's written lanes.
        a_do_d = a_do_q;
        if (a_oe && user_en) begin
            a_do_d = same ? ((a_old & ~b_bm) | (b_di & b_bm)) : a_old;
        end
        b_do_d = b_do_q;
        if (b_oe && user_en) begin
            b_do_d = same ? ((b_old & ~a_bm) | (a_di & a_bm)) : b_old;
        end

        coll_ww_d = |ovl;
    end

    always_ff @(posedge CK) begin
        if (state_q == S_CLEAR) begin
            mem_q[clr_cnt_q] <= '0;
        end else begin
            if (a_we_d) mem_q[a_addr] <= a_wdata_d;
            if (b_we_d) mem_q[b_addr] <= b_wdata_d;
        end
    end

    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            a_do_q    <= '0;
            b_do_q    <= '0;
            coll_ww_q <= 1'b0;
        end else begin
            a_do_q    <= a_do_d;
            b_do_q    <= b_do_d;
            coll_ww_q <= coll_ww_d;
        end
    end

    always_ff @(posedge CK or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            clr_cnt_q  <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    clr_done_q <= 1'b0;
                    if (clr_req) begin
                        state_q    <= S_CLEAR;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt_q == CNT_LAST) begin
                        state_q    <= S_DONE;
                        clr_cnt_q  <= '0;
                        clr_busy_q <= 1'b0;
                        clr_done_q <= 1'b1;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    end
                end
                S_DONE: begin
                    state_q    <= S_IDLE;
                    clr_done_q <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    clr_cnt_q  <= '0;
                    clr_busy_q <= 1'b0;
                    clr_done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef LB_COLL_CNT_EN
    logic [15:0] coll_cnt_q, coll_cnt_d;

    always_comb begin
        coll_cnt_d = coll_cnt_q;
        if (coll_cnt_clr) begin
            coll_cnt_d = '0;
        end else if (coll_ww_d && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_d = coll_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CK or posedge rst) begin
        if (rst) coll_cnt_q <= '0;
        else     coll_cnt_q <= coll_cnt_d;
    end

    assign coll_cnt = coll_cnt_q;
`endif

    assign a_do     = a_do_q;
    assign b_do     = b_do_q;
    assign coll_ww  = coll_ww_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_local_buffer_dp.sv
// Scoreboard bench for local_buffer_dp: lane masks, forwarding, collisions, clear and reset-mid-clear.
module tb_local_buffer_dp;

    localparam int DATA_W = 128;
    localparam int LANES  = 8;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic              CK = 1'b0;
    logic              rst;
    logic              a_oe, b_oe;
    logic [LANES-1:0]  a_webn, b_webn;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic [DATA_W-1:0] a_di, b_di, a_do, b_do;
    logic              clr_req, clr_busy, clr_done, coll_ww;
    logic              coll_cnt_clr;
`ifdef LB_COLL_CNT_EN
    logic [15:0]       coll_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [DATA_W-1:0] exp_a_q[$];
    logic [DATA_W-1:0] exp_b_q[$];

    local_buffer_dp #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .CK(CK), .rst(rst),
        .a_oe(a_oe), .a_webn(a_webn), .a_addr(a_addr), .a_di(a_di), .a_do(a_do),
        .b_oe(b_oe), .b_webn(b_webn), .b_addr(b_addr), .b_di(b_di), .b_do(b_do),
        .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done), .coll_ww(coll_ww)
`ifdef LB_COLL_CNT_EN
        , .coll_cnt_clr(coll_cnt_clr), .coll_cnt(coll_cnt)
`endif
    );

    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic idle_inputs();
        a_oe = 0; a_webn = '1; a_addr = '0; a_di = '0;
        b_oe = 0; b_webn = '1; b_addr = '0; b_di = '0;
        clr_req = 0; coll_cnt_clr = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        idle_inputs();
        step();
        step();
        n_tests++; if (a_do !== '0) begin n_fail++; $display("FAIL reset_a_do got=%h want=0", a_do); end
        n_tests++; if (b_do !== '0) begin n_fail++; $display("FAIL reset_b_do got=%h want=0", b_do); end
        n_tests++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", clr_busy); end
        n_tests++; if (clr_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", clr_done); end
        n_tests++; if (coll_ww !== 1'b0) begin n_fail++; $display("FAIL reset_coll got=%b want=0", coll_ww); end
        rst = 0;
        step();
    endtask

    task automatic test_lane_mask();
        logic [DATA_W-1:0] d0, x1, x2, exp;
        d0 = 128'h00112233445566778899AABBCCDDEEFF;
        x1 = {8{16'h1357}};
        x2 = {8{16'h2468}};
        a_addr = 5; a_webn = 8'h00; a_di = d0;
        step();
        a_webn = 8'hFE; a_di = '0;
        step();
        idle_inputs();
        b_oe = 1; b_addr = 5;
        exp_b_q.push_back({d0[127:16], 16'h0000});
        step();
        b_oe = 0;
        exp = exp_b_q.pop_front();
        n_tests++; if (b_do !== exp) begin n_fail++; $display("FAIL lane_mask got=%h want=%h", b_do, exp); end
        step();
        n_tests++; if (b_do !== {d0[127:16], 16'h0000}) begin n_fail++; $display("FAIL oe_hold got=%h want=%h", b_do, {d0[127:16], 16'h0000}); end
        a_addr = 6; a_webn = 8'h00; a_di = x1;
        step();
        a_di = x2; a_oe = 1;
        exp_a_q.push_back(x1);
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL read_first got=%h want=%h", a_do, exp); end
        a_webn = '1;
        exp_a_q.push_back(x2);
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL read_after_write got=%h want=%h", a_do, exp); end
        idle_inputs();
    endtask

    task automatic test_forwarding();
        logic [DATA_W-1:0] exp;
        a_addr = 9; a_webn = 8'h00; a_di = '1;
        step();
        a_webn = 8'hF0; a_di = '0;
        b_oe = 1; b_addr = 9;
        exp_b_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        step();
        exp = exp_b_q.pop_front();
        n_tests++; if (b_do !== exp) begin n_fail++; $display("FAIL forward got=%h want=%h", b_do, exp); end
        idle_inputs();
        a_oe = 1; a_addr = 9; b_oe = 1; b_addr = 9;
        exp_a_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        exp_b_q.push_back({64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL dual_read_a got=%h want=%h", a_do, exp); end
        exp = exp_b_q.pop_front();
        n_tests++; if (b_do !== exp) begin n_fail++; $display("FAIL dual_read_b got=%h want=%h", b_do, exp); end
        idle_inputs();
    endtask

    task automatic test_ww_collision();
        logic [DATA_W-1:0] exp;
        a_addr = 3; a_webn = 8'h00; a_di = {32{4'hA}};
        b_addr = 3; b_webn = 8'h0F; b_di = {32{4'hB}};
        step();
        n_tests++; if (coll_ww !== 1'b1) begin n_fail++; $display("FAIL coll_pulse got=%b want=1", coll_ww); end
        idle_inputs();
        a_oe = 1; a_addr = 3;
        exp_a_q.push_back({32{4'hA}});
        step();
        n_tests++; if (coll_ww !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle got=%b want=0", coll_ww); end
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL coll_a_wins got=%h want=%h", a_do, exp); end
        idle_inputs();
        a_addr = 3; a_webn = 8'h0F; a_di = {32{4'hC}};
        b_addr = 3; b_webn = 8'hF0; b_di = {32{4'hD}};
        step();
        n_tests++; if (coll_ww !== 1'b0) begin n_fail++; $display("FAIL disjoint_coll got=%b want=0", coll_ww); end
        idle_inputs();
        a_oe = 1; a_addr = 3;
        exp_a_q.push_back({{16{4'hC}}, {16{4'hD}}});
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL disjoint_merge got=%h want=%h", a_do, exp); end
        idle_inputs();
    endtask

    task automatic test_clear();
        logic [DATA_W-1:0] exp, held;
        int busy_cnt, done_cnt;
        for (int k = 0; k < DEPTH / 2; k++) begin
            a_addr = ADDR_W'(k);      a_webn = 8'h00; a_di = {16{8'(k + 1)}};
            b_addr = ADDR_W'(k + 64); b_webn = 8'h00; b_di = {16{8'(k + 65)}};
            step();
        end
        idle_inputs();
        b_oe = 1; b_addr = 5;
        exp_b_q.push_back({16{8'd6}});
        step();
        exp = exp_b_q.pop_front();
        n_tests++; if (b_do !== exp) begin n_fail++; $display("FAIL fill_check got=%h want=%h", b_do, exp); end
        held = exp;
        idle_inputs();
        clr_req = 1;
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 140; i++) begin
            step();
            if (i == 1) clr_req = 0;
            if (clr_busy) busy_cnt++;
            if (clr_done) done_cnt++;
            if (i == 11) begin
                n_tests++; if (b_do !== held) begin n_fail++; $display("FAIL busy_read_hold got=%h want=%h", b_do, held); end
                idle_inputs();
            end
            if (i == 10) begin
                a_addr = 2; a_webn = 8'h00; a_di = '1;
                b_oe = 1; b_addr = 7;
            end
        end
        n_tests++; if (busy_cnt != DEPTH) begin n_fail++; $display("FAIL busy_len got=%0d want=%0d", busy_cnt, DEPTH); end
        n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL done_pulses got=%0d want=1", done_cnt); end
        for (int k = 0; k < DEPTH / 2; k++) begin
            a_oe = 1; a_addr = ADDR_W'(k);
            b_oe = 1; b_addr = ADDR_W'(k + 64);
            exp_a_q.push_back('0);
            exp_b_q.push_back('0);
            step();
            exp = exp_a_q.pop_front();
            n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL cleared_a addr=%0d got=%h want=%h", k, a_do, exp); end
            exp = exp_b_q.pop_front();
            n_tests++; if (b_do !== exp) begin n_fail++; $display("FAIL cleared_b addr=%0d got=%h want=%h", k + 64, b_do, exp); end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_clear();
        logic [DATA_W-1:0] v1, exp;
        int done_cnt;
        v1 = {8{16'h1234}};
        a_addr = 39; a_webn = 8'h00; a_di = v1;
        b_addr = 40; b_webn = 8'h00; b_di = v1;
        step();
        idle_inputs();
        a_addr = 41; a_webn = 8'h00; a_di = v1;
        step();
        idle_inputs();
        clr_req = 1;
        step();
        clr_req = 0;
        for (int i = 0; i < 40; i++) step();
        n_tests++; if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL pre_rst_busy got=%b want=1", clr_busy); end
        rst = 1;
        #1;
        n_tests++; if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got=%b want=0", clr_busy); end
        step();
        rst = 0;
        done_cnt = 0;
        for (int i = 0; i < 140; i++) begin
            step();
            if (clr_done) done_cnt++;
        end
        n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL rst_no_done got=%0d want=0", done_cnt); end
        a_oe = 1; a_addr = 39;
        exp_a_q.push_back('0);
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL entry39 got=%h want=%h", a_do, exp); end
        a_addr = 40;
        exp_a_q.push_back(v1);
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL entry40 got=%h want=%h", a_do, exp); end
        a_addr = 41;
        exp_a_q.push_back(v1);
        step();
        exp = exp_a_q.pop_front();
        n_tests++; if (a_do !== exp) begin n_fail++; $display("FAIL entry41 got=%h want=%h", a_do, exp); end
        idle_inputs();
    endtask

`ifdef LB_COLL_CNT_EN
    task automatic test_coll_cnt();
        n_tests++; if (coll_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_start got=%0d want=0", coll_cnt); end
        for (int i = 0; i < 3; i++) begin
            a_addr = 20; a_webn = 8'h00; a_di = '1;
            b_addr = 20; b_webn = 8'h00; b_di = '0;
            step();
            idle_inputs();
            step();
        end
        n_tests++; if (coll_cnt !== 16'd3) begin n_fail++; $display("FAIL cnt_three got=%0d want=3", coll_cnt); end
        a_addr = 20; a_webn = 8'h00; a_di = '1;
        b_addr = 20; b_webn = 8'h00; b_di = '0;
        coll_cnt_clr = 1;
        step();
        n_tests++; if (coll_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_clr_prio got=%0d want=0", coll_cnt); end
        n_tests++; if (coll_ww !== 1'b1) begin n_fail++; $display("FAIL cnt_clr_coll got=%b want=1", coll_ww); end
        idle_inputs();
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_lane_mask();
        test_forwarding();
        test_ww_collision();
        test_clear();
        test_reset_mid_clear();
`ifdef LB_COLL_CNT_EN
        test_coll_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
